// File: rtl/acc_bank_drain.sv
// Drains one accumulator bank column to the PPU over a valid/ready stream.
// Optional clear-on-read (zero each row as it is read): define ACC_DRAIN_CLEAR_EN.
module acc_bank_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int DEPTH     = 12,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_rows,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    bank_addr,
  input  logic [ACC_WIDTH-1:0] bank_rd_data,
  output logic                 bank_wr_en,
  output logic                 bank_acc_mode,
  output logic [ACC_WIDTH-1:0] bank_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]    out_row,
  output logic                 out_last
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W:0]   rows_c;
  logic [ADDR_W:0]   rows_m1;
  logic              load;
  logic              is_last;

  assign rows_c  = (num_rows > DEPTH_W) ? DEPTH_W : num_rows;
  assign rows_m1 = rows_c - 1'b1;
  assign load    = !out_valid || out_ready;
  assign is_last = (idx == last_idx);

  assign busy          = (state != IDLE);
  assign bank_addr     = idx;
  assign bank_acc_mode = 1'b0;
  assign bank_wdata    = '0;

`ifdef ACC_DRAIN_CLEAR_EN
  // Reset cycle must not clear a row whose value was never captured.
  assign bank_wr_en = (state == READ) && load && !rst;
`else
  assign bank_wr_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      last_idx  <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            last_idx <= rows_m1[ADDR_W-1:0];
            if (rows_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              idx   <= '0;
            end
          end
        end
        READ: begin
          if (load) begin
            out_data  <= bank_rd_data;
            out_row   <= idx;
            out_valid <= 1'b1;
            out_last  <= is_last;
            if (is_last) state <= FLUSH;
            else         idx   <= idx + 1'b1;
          end
        end
        FLUSH: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_bank_drain.sv
// Bench for acc_bank_drain: behavioural bank model, drain vector table,
// and a scoreboard of expected beats.
module tb_acc_bank_drain;

  localparam int AW = 32;
  localparam int D  = 12;
  localparam int A  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [A:0]    num_rows = '0;
  logic          busy;
  logic          done;
  logic [A-1:0]  bank_addr;
  logic [AW-1:0] bank_rd_data;
  logic          bank_wr_en;
  logic          bank_acc_mode;
  logic [AW-1:0] bank_wdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic [A-1:0]  out_row;
  logic          out_last;

  always #5 clk = ~clk;

  acc_bank_drain #(.ACC_WIDTH(AW), .DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_rows(num_rows),
    .busy(busy),
    .done(done),
    .bank_addr(bank_addr),
    .bank_rd_data(bank_rd_data),
    .bank_wr_en(bank_wr_en),
    .bank_acc_mode(bank_acc_mode),
    .bank_wdata(bank_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_row(out_row),
    .out_last(out_last)
  );

  function automatic logic [AW-1:0] init_val(int i);
    case (i)
      0: init_val = 32'hFFFF_FFFB;
      1: init_val = 32'd7;
      2: init_val = 32'h7FFF_FFFF;
      3: init_val = 32'h8000_0000;
      default: init_val = (i >= 4 && i < D) ? AW'(i - 3) : '0;
    endcase
  endfunction

  // Bank model: async read, write on clock edge.
  logic [AW-1:0] mem [16];
  logic          preload = 1'b0;

  assign bank_rd_data = mem[bank_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (bank_wr_en) begin
      mem[bank_addr] <= bank_acc_mode ? mem[bank_addr] + bank_wdata
                                      : bank_wdata;
    end
  end

  int applied = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [AW-1:0] exp_mem [16];

  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
  endtask

  typedef struct {
    logic [AW-1:0] data;
    logic [A-1:0]  row;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t q[$];

  typedef struct {
    int          nr;
    logic [31:0] stall;
    int          restart;
    int          exp_done;
    bit          reload;
  } vec_t;

  vec_t vecs [7];

  task automatic run_drain(input vec_t v);
    int            rows;
    int            dones;
    logic          wr_seen;
    logic          held;
    logic [AW-1:0] pd;
    logic [A-1:0]  pr;
    logic [A-1:0]  pa;
    logic          pl;
    beat_t         b;
    rows    = (v.nr > D) ? D : v.nr;
    dones   = 0;
    wr_seen = 1'b0;
    held    = 1'b0;
    if (v.reload) do_preload();
    for (int i = 0; i < rows; i++)
      q.push_back('{exp_mem[i], A'(i), (i == rows - 1), 2 + i});
    for (int c = 0; c <= v.exp_done + 3; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == v.restart);
      num_rows  = (A+1)'(v.nr);
      out_ready = !v.stall[c];
      @(negedge clk);
      if (held) begin
        chk("hold_data", out_data, pd);
        chk("hold_row", 32'(out_row), 32'(pr));
        chk("hold_last", 32'(out_last), 32'(pl));
        chk("hold_addr", 32'(bank_addr), 32'(pa));
      end
      if (v.stall != 0 && c >= 3 && c <= 5)
        chk("stall_addr", 32'(bank_addr), 32'd2);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          b = q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_row", 32'(out_row), 32'(b.row));
          chk("beat_last", 32'(out_last), 32'(b.last));
          if (v.stall == 0 && v.restart < 0)
            chk("beat_cycle", c, b.cyc);
        end
      end
      held = out_valid && !out_ready;
      pd   = out_data;
      pr   = out_row;
      pl   = out_last;
      pa   = bank_addr;
      if (done) begin
        dones++;
        chk("done_cycle", c, v.exp_done);
      end
      chk("busy", 32'(busy), 32'(c >= 1 && c <= v.exp_done));
      if (bank_wr_en) wr_seen = 1'b1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_count", dones, 1);
    chk("beats_left", q.size(), 0);
    q.delete();
`ifdef ACC_DRAIN_CLEAR_EN
    for (int i = 0; i < rows; i++) exp_mem[i] = '0;
    chk("wr_en_used", 32'(wr_seen), 32'(rows > 0));
`else
    chk("wr_en_idle", 32'(wr_seen), 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{12, 32'h0,  -1, 14, 1'b1};
    vecs[1] = '{12, 32'h0,  -1, 14, 1'b0};
    vecs[2] = '{12, 32'h38, -1, 17, 1'b1};
    vecs[3] = '{0,  32'h0,  -1, 1,  1'b1};
    vecs[4] = '{15, 32'h0,  -1, 14, 1'b1};
    vecs[5] = '{1,  32'h0,  -1, 3,  1'b1};
    vecs[6] = '{12, 32'h0,   4, 14, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_addr", 32'(bank_addr), 32'd0);
    chk("rst_wr_en", 32'(bank_wr_en), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_drain(vecs[k]);

    // Reset in the middle of a drain, then a clean drain.
    do_preload();
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      num_rows  = 5'd12;
      out_ready = 1'b1;
      rst       = (c == 6);
      @(negedge clk);
      if (c == 5) chk("mid_valid", 32'(out_valid), 32'd1);
      if (c == 7) begin
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_last", 32'(out_last), 32'd0);
      end
    end
    rst = 1'b0;
`ifdef ACC_DRAIN_CLEAR_EN
    for (int i = 0; i < 5; i++) exp_mem[i] = '0;
`endif
    run_drain('{12, 32'h0, -1, 14, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_bank_drain.md
Name: acc_bank_drain

Overview:
- Read-side sequencer for a single_column_bank accumulator column.
- After the array finishes accumulating a tile, this block walks bank addresses 0..N-1 and samples the bank's asynchronous read port (out_acc).
- It streams each value to the PPU over a valid/ready interface, with a last marker and a completion pulse.
- With clear-on-read compiled in, it drives the bank's write port to zero each entry as it is read, readying the bank for the next tile.

Parameters:
- ACC_WIDTH, 32: accumulator word width; matches the bank data width.
- DEPTH, 12: number of valid bank rows.
- ADDR_W, 4: bank address width; requires DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to drain; sampled in IDLE only.
- num_rows  in  ADDR_W+1  rows to drain; latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the drain completes.
- bank_addr  out  ADDR_W  bank address (bank addr).
- bank_rd_data  in  ACC_WIDTH  bank out_acc, combinational function of bank_addr.
- bank_wr_en  out  1  bank wr_en; clear-on-read only.
- bank_acc_mode  out  1  bank acc_mode; constant 0.
- bank_wdata  out  ACC_WIDTH  bank in_psum; constant 0.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from PPU.
- out_data  out  ACC_WIDTH  registered accumulator value.
- out_row  out  ADDR_W  bank row of out_data.
- out_last  out  1  marks the final beat of the drain.

Behaviour:
- Reset (sync, rst=1 at edge), regardless of state:
  - State = IDLE; index = 0.
  - busy, done, out_valid, out_last, bank_wr_en = 0.
  - out_data = 0, out_row = 0, bank_addr = 0.
  - A drain in flight is abandoned. No partial bank clear continues after reset.
- States: IDLE, READ, FLUSH, DONE.
- IDLE:
  - start=1 -> latch rows = min(num_rows, DEPTH).
  - rows==0 -> go to DONE. Otherwise go to READ with idx=0.
  - start while not IDLE is ignored.
- READ:
  - bank_addr = idx.
  - load = !out_valid || out_ready.
  - On load:
    - out_data <= bank_rd_data; out_row <= idx; out_valid <= 1.
    - out_last <= (idx == rows-1).
    - If idx == rows-1, go to FLUSH; else idx <= idx+1.
  - No load: hold idx and bank_addr.
- FLUSH: on out_valid && out_ready, clear out_valid and out_last, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Handshake:
  - A beat transfers on out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_row and out_last stay stable.
  - out_valid never deasserts without a transfer, except on rst.
  - Throughput is 1 beat/cycle with out_ready held high; zero bubbles between beats.
- Latency, start accepted at cycle T:
  - First beat valid at T+2.
  - With out_ready=1 throughout, the last beat is at T+1+rows and done at T+2+rows.
  - busy is high from T+1 through the done cycle inclusive.
- bank_addr in IDLE, FLUSH and DONE is held at its last value; bank_wr_en = 0 in these states.
- No arithmetic: data passes through bit-exact, including sign.

Optional Feature:
- Macro: ACC_DRAIN_CLEAR_EN.
- Defined:
  - bank_wr_en = 1 exactly in READ cycles where load=1, so the bank writes 0 to mem[idx] at the same edge out_data captures the old value.
  - After a full drain, rows 0..rows-1 read 0.
  - Rows not yet loaded when rst hits keep their values.
- Undefined: bank_wr_en tied 0; the bank is never modified.

Test Plan:
- Basic drain: bank rows 0..11 preload -5, 7, 0x7FFFFFFF, 0x80000000, 1..8; num_rows=12; out_ready=1; start at T.
  - Beats at T+2..T+13 carry those values in order with out_row 0..11.
  - out_last only at T+13; done at T+14; busy T+1..T+14.
- Backpressure: same preload; out_ready=0 on cycles T+3..T+5.
  - Beat row 1 held stable for 3 cycles; bank_addr holds at 2.
  - Order intact; done at T+17.
- Bounds:
  - num_rows=0 -> no beats; done at T+1.
  - num_rows=15 -> exactly 12 beats, last at row 11.
  - num_rows=1 -> single beat, with out_last=1.
- Start while busy: a second start pulse at T+4 is ignored; exactly one done and 12 beats.
- Reset mid-drain: rst=1 at T+6.
  - Next cycle: out_valid=0, busy=0, no done.
  - A fresh start then drains from row 0 correctly.
- ACC_DRAIN_CLEAR_EN: after the basic drain, a second drain returns 12 zeros.
  - Without the macro, the second drain returns the original values and bank_wr_en stays 0 throughout.
